// File: rtl/contador_bcd_desc_pkg.sv
// Shared types and BCD helpers for the BCD down-counter.
// States, digit limit, decrement and saturation functions (up to 8 digits).
package contador_bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int BCD_MAX_DIGITS = 8;

  // Subtract one with per-digit borrow; callers
  // truncate the result to their own width.
  function automatic logic [31:0] bcd_dec(
    input logic [31:0] v
  );
    logic [31:0] r;
    logic [3:0]  d;
    logic        b;
    r = '0;
    b = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!b) begin
        r[4*i +: 4] = d;
      end else if (d == 4'd0) begin
        r[4*i +: 4] = BCD_MAX_DIGIT;
      end else begin
        r[4*i +: 4] = d - 4'd1;
        b = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] bcd_sat(
    input logic [31:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_MAX_DIGIT) begin
        r[4*i +: 4] = BCD_MAX_DIGIT;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_desc_prescaler_n.sv
// Divide-by-DIV prescaler: counts 0..DIV-1 while en, tick on the last count.
// Ports: clk, reset (async low), clr, en -> tick.
module prescaler_n
  import contador_bcd_pkg::*;
#(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST =
    DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // With en low the count holds, so a pause
  // on the last count keeps it parked there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_bcd_desc.sv
// Loadable BCD down-counter/timer with load/start/pause strobes and done pulse.
// Ports: clk, reset (async low), load, load_val, start, pause -> q, busy, zero,
// done_tick. Macro CONTADOR_BCD_DESC_AUTORELOAD_EN enables auto-reload.
module contador_bcd_desc
  import contador_bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int DIV    = 50000000,
  parameter int DIV_W  = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] q,
  output logic                busy,
  output logic                zero,
  output logic                done_tick
);

  localparam int W = 4 * DIGITS;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   q_q;
  logic [W-1:0]   q_d;
  logic           done_q;
  logic           done_d;
  // Set by load; start from IDLE is ignored
  // until a value has been loaded.
  logic           armed_q;
  logic           armed_d;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
  logic [W-1:0]   reload_q;
  logic [W-1:0]   reload_d;
`endif

  logic           ld_go;
  logic           st_go;
  logic           ps_go;
  logic           pres_clr;
  logic           pres_en;
  logic           tick;
  logic           q_zero;
  logic           q_one;
  logic [W-1:0]   ld_sat;

  // Only the highest-priority strobe acts.
  assign ld_go = load;
  assign st_go = start && !load;
  assign ps_go = pause && !start && !load;

  assign q_zero = (q_q == '0);
  assign q_one  = (q_q == W'(1));
  assign ld_sat = W'(bcd_sat(32'(load_val)));

  assign pres_en = (state_q == RUN) &&
                   !ld_go && !ps_go;

  prescaler_n #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_pres (
    .clk   (clk),
    .reset (reset),
    .clr   (pres_clr),
    .en    (pres_en),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    done_d   = 1'b0;
    armed_d  = armed_q;
    pres_clr = 1'b0;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    unique case (1'b1)
      ld_go: begin
        q_d      = ld_sat;
        state_d  = IDLE;
        armed_d  = 1'b1;
        pres_clr = 1'b1;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
        reload_d = ld_sat;
`endif
      end
      st_go: begin
        unique case (state_q)
          IDLE: begin
            if (armed_q) begin
              if (q_zero) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d  = RUN;
                pres_clr = 1'b1;
              end
            end
          end
          PAUSE:   state_d = RUN;
          default: ;
        endcase
      end
      ps_go: begin
        if (state_q == RUN) begin
          state_d = PAUSE;
        end
      end
      default: ;
    endcase
    // tick is already masked by load and pause.
    if (tick) begin
      if (q_one) begin
        done_d = 1'b1;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
        if (reload_q != '0) begin
          q_d = reload_q;
        end else begin
          q_d     = '0;
          state_d = DONE;
        end
`else
        q_d     = '0;
        state_d = DONE;
`endif
      end else begin
        q_d = W'(bcd_dec(32'(q_q)));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q         = q_q;
  assign busy      = (state_q == RUN);
  assign zero      = q_zero;
  assign done_tick = done_q;

endmodule

// File: doc/contador_bcd_desc.md
Name: contador_bcd_desc

Overview:
Loadable 3-digit BCD down-counter and timer. It is the counting-down counterpart to the team's up-counters. A value is loaded, then decremented once per prescaler period, and a one-cycle done_tick is raised when the count reaches 000. The block sits between the user controls (load, start and pause strobes) and the BCD display and alarm logic.

Parameters:
DIGITS, 3, number of BCD digits; q width is 4*DIGITS.
DIV, 50000000, clk cycles per decrement; 1 s at 50 MHz. Must be at least 2.
DIV_W, 26, prescaler counter width. Requires 2**DIV_W >= DIV.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; reset=0 clears everything immediately.
load  input  1  strobe: capture load_val.
load_val  input  4*DIGITS  BCD preset value; digit i is bits [4i+3:4i].
start  input  1  strobe: begin or resume counting.
pause  input  1  strobe: freeze counting.
q  output  4*DIGITS  current BCD count.
busy  output  1  1 while in RUN.
zero  output  1  1 when q == 0.
done_tick  output  1  one-cycle pulse when the count completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, state=IDLE, prescaler=0, reload register=0.
  - busy=0, zero=1, done_tick=0.
- States: IDLE, RUN, PAUSE, DONE. Encoding lives in the package.
- Strobe priority in any state: load > start > pause. Only the highest active strobe takes effect in a cycle.
- load, in any state:
  - q <= load_val and reload register <= load_val; state <= IDLE; prescaler <= 0.
  - Any load_val digit > 9 is saturated to 9.
- start:
  - IDLE with q != 0: go to RUN, prescaler <= 0.
  - IDLE with q == 0: go to DONE; done_tick=1 on the next cycle.
  - PAUSE: go to RUN; the prescaler keeps its held value and resumes from it.
  - RUN or DONE: ignored.
- pause:
  - RUN: go to PAUSE; prescaler and q are frozen.
  - Other states: ignored.
- Decrement timing in RUN:
  - The prescaler counts 0..DIV-1. The tick is the cycle where prescaler == DIV-1; the prescaler wraps to 0 on the following edge.
  - On tick, q <= q-1 in BCD, registered, so q changes on the edge after the tick cycle.
  - Per-digit borrow rule: a digit at 0 becomes 9 and borrows from the next digit; otherwise the digit decrements by 1.
  - Example: 100 -> 099 -> 098.
- Completion:
  - When the tick occurs with q == 1, q <= 0 and state <= DONE.
  - done_tick is registered and high exactly one cycle, the first cycle in which q == 0.
- DONE: q holds 0. Only load exits DONE; start and pause are ignored.
- busy = (state == RUN). zero is combinational from q.
- Simultaneous events:
  - load in the same cycle as a tick: load wins; no decrement and no done_tick.
  - pause in the same cycle as a tick: pause wins; the tick is discarded and the prescaler holds at DIV-1, so the decrement fires on the first RUN cycle after resume.
- Reset during RUN: immediately returns to the reset values listed above.
- Wrap-around below 000 is impossible; the counter never decrements from 0.

Optional Feature:
CONTADOR_BCD_DESC_AUTORELOAD_EN.
- Defined:
  - On a completion tick (q == 1), if the reload register is non-zero: q <= reload register, state stays RUN, done_tick pulses for one cycle, q never shows 000, and the prescaler continues without a gap.
  - If the reload register is 0, behaviour is as without the macro.
- Undefined: behaviour exactly as in Behaviour; no reload register logic is synthesised.

Decomposition:
- Package contador_bcd_pkg:
  - state typedef and encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - BCD_MAX_DIGIT=4'd9;
  - function bcd_dec (multi-digit BCD decrement with borrow).
- One sub-module: prescaler_n, parameterised by DIV and DIV_W. Inputs clk, reset, clr, en; output tick (1 when count == DIV-1 and en=1).

Test Plan (bench uses DIV=4):
- Load 005, start -> q steps 004, 003, 002, 001, 000, one step every 4 cycles; done_tick high one cycle with q=000; busy falls in the same cycle.
- Load 100, start, run 2 ticks -> q = 099 then 098, checking the two-digit borrow.
- Load 012, start, pause after 6 cycles; hold 20 cycles; start -> q frozen during the pause; the next decrement comes after the remaining prescaler cycles, not a full period.
- Load 0F3 -> q = 093. Load 000 then start -> state DONE and done_tick pulses once. Start again in DONE -> no further pulse.
- Load 050, start, pull reset low mid-count asynchronously (not on a clock edge) -> q=000, busy=0, done_tick=0 immediately. After release, start is ignored until the next load.
- With CONTADOR_BCD_DESC_AUTORELOAD_EN: load 002, start -> q goes 001 then 002, repeating; done_tick pulses every 8 cycles; busy stays high.
